// File: rtl/cdc_fifo_pkg.sv
// ============================================================================
// Module  : cdc_fifo_pkg
// Brief   : Shared pointer-width and Gray helpers for both CDC FIFO pointer sides
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cdc_fifo_pkg;

  localparam int PTR_W_MAX = 32;

  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Full when the pointers differ only in the two MSBs (writer one lap ahead).
  function automatic logic full_cmp(input logic [PTR_W_MAX-1:0] wgray,
                                    input logic [PTR_W_MAX-1:0] rgray,
                                    input int                   width);
    logic [PTR_W_MAX-1:0] mask;
    logic [PTR_W_MAX-1:0] flip;
    mask = {PTR_W_MAX{1'b1}} >> (PTR_W_MAX - width);
    flip = PTR_W_MAX'(3) << (width - 2);
    return ((wgray ^ rgray ^ flip) & mask) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wptr_full_if.sv
// ============================================================================
// Module  : fifo_wptr_full_if
// Brief   : Write-side pointer bus between the FIFO writer and fifo_wptr_full
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wptr_full_if
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) ();

  localparam int P = ptr_w(ADDR_WIDTH);

  logic                  push_i;
  logic                  wen_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [P-1:0]          wptr_gray_o;
  logic [P-1:0]          rptr_gray_i;
  logic                  full_o;
  logic [P-1:0]          level_o;
  logic                  overflow_o;

  modport master (
    output push_i, rptr_gray_i,
    input  wen_o, waddr_o, wptr_gray_o, full_o, level_o, overflow_o
  );

  modport slave (
    input  push_i, rptr_gray_i,
    output wen_o, waddr_o, wptr_gray_o, full_o, level_o, overflow_o
  );

endinterface

`default_nettype wire

// File: rtl/gray_2_bin.sv
// ============================================================================
// Module  : gray_2_bin
// Brief   : Combinational Gray-to-binary converter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_2_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/gray_sync.sv
// ============================================================================
// Module  : gray_sync
// Brief   : Multi-flop synchronizer for a Gray-coded pointer, async reset to 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d_i;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q_o = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fifo_wptr_full.sv
// ============================================================================
// Module  : fifo_wptr_full
// Brief   : Write-domain pointer, full flag, occupancy and overflow for CDC FIFO
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wptr_full
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  fifo_wptr_full_if.slave  bus
);

  localparam int P = ptr_w(ADDR_WIDTH);

  logic [P-1:0] r_wbin;
  logic [P-1:0] r_wgray;
  logic [P-1:0] r_level;
  logic         r_full;
  logic         r_ovf;

  logic         w_wen;
  logic [P-1:0] w_wbin_next;
  logic [P-1:0] w_wgray_next;
  logic [P-1:0] w_rq;
  logic [P-1:0] w_rbin;
  logic         w_full_next;

  assign w_wen        = bus.push_i & ~r_full;
  assign w_wbin_next  = r_wbin + P'(w_wen);
  assign w_wgray_next = P'(bin2gray(PTR_W_MAX'(w_wbin_next)));
  assign w_full_next  = full_cmp(PTR_W_MAX'(w_wgray_next), PTR_W_MAX'(w_rq), P);

  gray_sync #(
    .WIDTH  (P),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .d_i     (bus.rptr_gray_i),
    .q_o     (w_rq)
  );

  gray_2_bin #(
    .WIDTH (P)
  ) u_rptr_g2b (
    .gray_i (w_rq),
    .bin_o  (w_rbin)
  );

  // The synchronized read pointer can only lag, so level/full err on the full side.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_level <= w_wbin_next - w_rbin;
      r_full  <= w_full_next;
      r_ovf   <= bus.push_i & r_full;
    end
  end

  assign bus.wen_o       = w_wen;
  assign bus.waddr_o     = r_wbin[ADDR_WIDTH-1:0];
  assign bus.wptr_gray_o = r_wgray;
  assign bus.full_o      = r_full;
  assign bus.level_o     = r_level;
  assign bus.overflow_o  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
// ============================================================================
// Module  : tb_fifo_wptr_full
// Brief   : Directed scoreboard bench for fifo_wptr_full (ADDR_WIDTH=4, SYNC_STAGES=2)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_wptr_full;

  logic clk = 1'b0;
  logic arst_n;

  always #5 clk = ~clk;

  fifo_wptr_full_if #(.ADDR_WIDTH(4)) bus ();

  fifo_wptr_full #(
    .ADDR_WIDTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus)
  );

  // mask bits: 0 full, 1 level, 2 gray, 3 overflow, 4 wen, 5 waddr
  typedef struct {
    string      name;
    logic [5:0] mask;
    logic       full;
    logic [4:0] level;
    logic [4:0] gray;
    logic       ovf;
    logic       wen;
    logic [3:0] waddr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   hd_en = 1'b0;
  logic [4:0] prev_gray = '0;

  function automatic logic [4:0] g(input int x);
    logic [4:0] b;
    b = 5'(x);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.mask[0]) chk(e.name, "full",     int'(bus.full_o),      int'(e.full));
      if (e.mask[1]) chk(e.name, "level",    int'(bus.level_o),     int'(e.level));
      if (e.mask[2]) chk(e.name, "gray",     int'(bus.wptr_gray_o), int'(e.gray));
      if (e.mask[3]) chk(e.name, "overflow", int'(bus.overflow_o),  int'(e.ovf));
      if (e.mask[4]) chk(e.name, "wen",      int'(bus.wen_o),       int'(e.wen));
      if (e.mask[5]) chk(e.name, "waddr",    int'(bus.waddr_o),     int'(e.waddr));
    end
    if (hd_en && (bus.wptr_gray_o != prev_gray))
      chk("gray_step", "hamming", $countones(bus.wptr_gray_o ^ prev_gray), 1);
    prev_gray = bus.wptr_gray_o;
  end

  task automatic cyc(input logic push, input logic [4:0] rg, input string nm,
                     input logic [5:0] m, input logic e_full, input logic [4:0] e_lvl,
                     input logic [4:0] e_gray, input logic e_ovf, input logic e_wen,
                     input logic [3:0] e_wa);
    exp_t e;
    bus.push_i      = push;
    bus.rptr_gray_i = rg;
    e = '{name: nm, mask: m, full: e_full, level: e_lvl, gray: e_gray,
          ovf: e_ovf, wen: e_wen, waddr: e_wa};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_err++;
    summary();
    $finish;
  end

  initial begin
    exp_t e;
    int   w;
    arst_n          = 1'b0;
    bus.push_i      = 1'b0;
    bus.rptr_gray_i = '0;
    @(posedge clk);
    #1;
    cyc(0, 5'd0, "reset", 6'h3F, 0, 5'd0, 5'd0, 0, 0, 4'd0);
    arst_n = 1'b1;

    // Fill
    for (int k = 0; k < 16; k++)
      cyc(1, 5'd0, "fill", 6'h3F, 0, 5'(k), g(k), 0, 1, 4'(k));

    // Push at full, overflow pulse
    cyc(1, 5'd0, "full_push", 6'h3F, 1, 5'd16, 5'b11000, 0, 0, 4'd0);
    cyc(0, 5'd0, "ovf_pulse", 6'h3F, 1, 5'd16, 5'b11000, 1, 0, 4'd0);
    cyc(0, 5'd0, "ovf_clear", 6'h3F, 1, 5'd16, 5'b11000, 0, 0, 4'd0);

    // Drain visibility: 3 edges through the synchronizer and flag register
    cyc(0, 5'b00110, "drain_e0", 6'h03, 1, 5'd16, 5'd0, 0, 0, 4'd0);
    cyc(0, 5'b00110, "drain_e1", 6'h03, 1, 5'd16, 5'd0, 0, 0, 4'd0);
    cyc(0, 5'b00110, "drain_e2", 6'h03, 1, 5'd16, 5'd0, 0, 0, 4'd0);
    cyc(0, 5'b00110, "drain_e3", 6'h03, 0, 5'd12, 5'd0, 0, 0, 4'd0);

    // Wrap-around: the reader leads by the synchronizer lag so the
    // synchronized view sits exactly 8 behind the writer.
    repeat (3) cyc(0, g(8), "settle", 6'h00, 0, 5'd0, 5'd0, 0, 0, 4'd0);
    hd_en = 1'b1;
    for (int j = 0; j <= 42; j++) begin
      logic p;
      p = (j >= 2) && (j < 42);
      w = 16 + ((j < 2) ? 0 : j - 2);
      cyc(p, g(j + 9), "wrap", 6'h3F, 0, 5'd8, g(w), 0, p, 4'(w));
    end
    hd_en = 1'b0;

    // Build level 7, then async reset between edges
    repeat (3) cyc(0, g(19), "pre", 6'h00, 0, 5'd0, 5'd0, 0, 0, 4'd0);
    repeat (2) cyc(1, g(19), "pre", 6'h00, 0, 5'd0, 5'd0, 0, 0, 4'd0);
    cyc(0, g(19), "pre_rst", 6'h06, 0, 5'd7, g(26), 0, 0, 4'd0);
    bus.push_i      = 1'b0;
    bus.rptr_gray_i = '0;
    e = '{name: "rst_async", mask: 6'h3F, full: 0, level: 0, gray: 0, ovf: 0, wen: 0, waddr: 0};
    q.push_back(e);
    #1 arst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 5'd0, "rst_hold", 6'h3F, 0, 5'd0, 5'd0, 0, 0, 4'd0);
    arst_n = 1'b1;
    cyc(1, 5'd0, "post_rst_push", 6'h3F, 0, 5'd0, 5'd0, 0, 1, 4'd0);
    for (int k = 1; k < 16; k++)
      cyc(1, 5'd0, "refill", 6'h3F, 0, 5'(k), g(k), 0, 1, 4'(k));

    // Push held while the read pointer steps 0->1 at full
    cyc(1, 5'b00001, "coin_a",      6'h3F, 1, 5'd16, 5'b11000, 0, 0, 4'd0);
    cyc(1, 5'b00001, "coin_b",      6'h3F, 1, 5'd16, 5'b11000, 1, 0, 4'd0);
    cyc(1, 5'b00001, "coin_c",      6'h3F, 1, 5'd16, 5'b11000, 1, 0, 4'd0);
    cyc(1, 5'b00001, "coin_write",  6'h3F, 0, 5'd15, 5'b11000, 1, 1, 4'd0);
    cyc(1, 5'b00001, "coin_refull", 6'h3F, 1, 5'd16, 5'b11001, 0, 0, 4'd1);
    cyc(0, 5'b00001, "coin_ovf",    6'h3F, 1, 5'd16, 5'b11001, 1, 0, 4'd1);

    repeat (3) @(posedge clk);
    chk("scoreboard", "pending", q.size(), 0);
    summary();
    $finish;
  end

endmodule

`default_nettype wire
